acc_reduce_pipe: RTL and testbench

ACC_REDUCE_PIPE -- requirements
Module: acc_reduce_pipe

---
 rtl/acc_pkg.sv | 23 ++
 rtl/acc_reduce_tree.sv | 59 +++++
 rtl/acc_reduce_pipe.sv | 137 +++++++++++++
 tb/tb_acc_reduce_pipe.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulate/reduce pipeline.
//   - acc_mode_e       : mode encodings presented on the 'mode' input.
//   - mode_accumulates : true for modes that sum beats into the accumulator.
// No ports (package).
// -----------------------------------------------------------------------------
package acc_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_PAIR   = 2'b01,
        MODE_RSVD   = 2'b10,  // treated exactly like bypass
        MODE_FULL   = 2'b11
    } acc_mode_e;

    // Only pairwise and full reduce build multi-beat groups; bypass and the
    // reserved code close the group on every beat.
    function automatic logic mode_accumulates(input logic [1:0] m);
        return (m == MODE_PAIR) || (m == MODE_FULL);
    endfunction

endpackage

// File: rtl/acc_reduce_tree.sv
// -----------------------------------------------------------------------------
// acc_reduce_tree
// Combinational lane reduction for one input beat.
//   bypass / reserved : each lane sign-extended to ACC_W
//   pairwise          : lane k = in[2k] + in[2k+1] for k < NUM_LANES/2, rest 0
//   full              : lane 0 = sum of all lanes, rest 0
// Ports:
//   in_data  [NUM_LANES*IN_W-1:0]  input lanes, lane 0 in LSBs
//   mode     [1:0]                 effective mode for this beat
//   red_data [NUM_LANES*ACC_W-1:0] reduced vector, lane 0 in LSBs
// ACC_W >= IN_W + log2(NUM_LANES), so no intermediate sum here can overflow.
// -----------------------------------------------------------------------------
module acc_reduce_tree
    import acc_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_W      = 16,
    parameter int ACC_W     = 32
) (
    input  logic [NUM_LANES*IN_W-1:0]  in_data,
    input  logic [1:0]                 mode,
    output logic [NUM_LANES*ACC_W-1:0] red_data
);

    logic [ACC_W-1:0] lane_ext [NUM_LANES];
    logic [ACC_W-1:0] full_sum;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ext
        assign lane_ext[i] = {{(ACC_W-IN_W){in_data[i*IN_W+IN_W-1]}},
                              in_data[i*IN_W +: IN_W]};
    end

    always_comb begin
        full_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            full_sum = full_sum + lane_ext[i];
        end
    end

    always_comb begin
        red_data = '0;
        case (mode)
            MODE_PAIR: begin
                for (int k = 0; k < NUM_LANES/2; k++) begin
                    red_data[k*ACC_W +: ACC_W] = lane_ext[2*k] + lane_ext[2*k+1];
                end
            end
            MODE_FULL: begin
                red_data[ACC_W-1:0] = full_sum;
            end
            default: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    red_data[i*ACC_W +: ACC_W] = lane_ext[i];
                end
            end
        endcase
    end

endmodule

// File: rtl/acc_reduce_pipe.sv
// -----------------------------------------------------------------------------
// acc_reduce_pipe
// Reduces each accepted beat (acc_reduce_tree) and, in pairwise/full mode,
// accumulates beats lane-wise until a closing beat; the group total is then
// registered on the output together with its beat count.
// Optional feature macro: ACC_SAT_EN -- when defined, every lane update
// saturates to the signed ACC_W range; otherwise lane sums wrap.
// Ports:
//   clk, rst (async, active-high)
//   mode[1:0]              00 bypass, 01 pairwise, 11 full, 10 as bypass;
//                          sampled on the first beat of a group
//   in_valid/in_ready      input handshake
//   in_data                NUM_LANES*IN_W, lane 0 in LSBs
//   in_last                closes an accumulating group
//   out_valid/out_ready    output handshake
//   out_data               NUM_LANES*ACC_W, lane 0 in LSBs
//   out_count              beats in the emitted group (saturating)
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; out_data/out_count hold while out_valid & !out_ready, and in_ready is
// !out_valid | out_ready so a result can be replaced in the same edge it is
// consumed.
// -----------------------------------------------------------------------------
module acc_reduce_pipe
    import acc_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int IN_W      = 16,
    parameter int ACC_W     = 32,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_LANES*IN_W-1:0]  in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_LANES*ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]           out_count
);

    logic [NUM_LANES*ACC_W-1:0] acc_q;
    logic [NUM_LANES*ACC_W-1:0] red_data;
    logic [NUM_LANES*ACC_W-1:0] sum_data;
    logic [CNT_W-1:0]           cnt_q;
    logic [CNT_W-1:0]           cnt_inc;
    logic [1:0]                 mode_q;
    logic [1:0]                 eff_mode;
    logic                       group_open;
    logic                       accept;
    logic                       close;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // A non-zero beat count means a group is in progress (the counter
    // saturates rather than wrapping, so it never returns to zero mid-group).
    assign group_open = (cnt_q != '0);
    assign eff_mode   = group_open ? mode_q : mode;
    assign close      = in_last || !mode_accumulates(eff_mode);
    assign cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    acc_reduce_tree #(
        .NUM_LANES (NUM_LANES),
        .IN_W      (IN_W),
        .ACC_W     (ACC_W)
    ) u_tree (
        .in_data  (in_data),
        .mode     (eff_mode),
        .red_data (red_data)
    );

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide_sum;

    // One guard bit per lane: the sum overflowed when the guard bit and the
    // sign bit disagree, and the guard bit gives the true sign.
    always_comb begin
        sum_data = '0;
        wide_sum = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            wide_sum = {acc_q[i*ACC_W+ACC_W-1], acc_q[i*ACC_W +: ACC_W]}
                     + {red_data[i*ACC_W+ACC_W-1], red_data[i*ACC_W +: ACC_W]};
            if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
                sum_data[i*ACC_W +: ACC_W] = wide_sum[ACC_W] ? SAT_MIN : SAT_MAX;
            end else begin
                sum_data[i*ACC_W +: ACC_W] = wide_sum[ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        sum_data = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            sum_data[i*ACC_W +: ACC_W] = acc_q[i*ACC_W +: ACC_W]
                                       + red_data[i*ACC_W +: ACC_W];
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else begin
            if (accept) begin
                if (close) begin
                    out_data  <= sum_data;
                    out_count <= cnt_inc;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                end else begin
                    acc_q <= sum_data;
                    cnt_q <= cnt_inc;
                    if (!group_open) begin
                        mode_q <= mode;
                    end
                end
            end
            if (accept && close) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_acc_reduce_pipe.sv
// -----------------------------------------------------------------------------
// tb_acc_reduce_pipe
// Scoreboard bench for acc_reduce_pipe (NUM_LANES=4, IN_W=16, ACC_W=20,
// CNT_W=8). The driver pushes the expected group result when a closing beat
// is accepted; the monitor compares the head of the queue on every cycle the
// output is (or should be) valid and pops it on a handshake.
// -----------------------------------------------------------------------------
module tb_acc_reduce_pipe;

    localparam int NL = 4;
    localparam int IW = 16;
    localparam int AW = 20;
    localparam int CW = 8;
    localparam int DW = NL*AW;
    localparam int EW = DW + CW;

    logic           clk;
    logic           rst;
    logic [1:0]     mode;
    logic           in_valid;
    logic           in_ready;
    logic [NL*IW-1:0] in_data;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  out_count;

    logic [EW-1:0]  exp_q[$];
    int             total = 0;
    int             bad   = 0;
    int             rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high

    // Reference model state: group open flag, latched mode, lane sums, beats.
    bit             m_open;
    logic [1:0]     m_mode;
    longint         m_acc [NL];
    int             m_cnt;

`ifdef ACC_SAT_EN
    localparam longint SMAX = (longint'(1) <<< (AW-1)) - 1;
    localparam longint SMIN = -(longint'(1) <<< (AW-1));
`endif

    acc_reduce_pipe #(
        .NUM_LANES (NL),
        .IN_W      (IW),
        .ACC_W     (AW),
        .CNT_W     (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NL*IW-1:0] pack4(input int a, input int b,
                                               input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    function automatic longint lane_update(input longint v);
`ifdef ACC_SAT_EN
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
`endif
        return v;
    endfunction

    task automatic model_clear();
        m_open = 1'b0;
        m_mode = 2'b00;
        m_cnt  = 0;
        foreach (m_acc[i]) m_acc[i] = 0;
    endtask

    // Apply one accepted beat to the reference model.
    task automatic model_beat(input logic [1:0] m, input logic [NL*IW-1:0] d,
                              input logic last);
        longint lanes [NL];
        longint red   [NL];
        longint total_sum;
        bit     byp;
        logic [EW-1:0] e;
        if (!m_open) m_mode = m;
        byp = (m_mode == 2'b00) || (m_mode == 2'b10);
        total_sum = 0;
        for (int i = 0; i < NL; i++) begin
            lanes[i] = longint'($signed(d[i*IW +: IW]));
            red[i]   = 0;
            total_sum += lanes[i];
        end
        if (m_mode == 2'b01) begin
            for (int k = 0; k < NL/2; k++) red[k] = lanes[2*k] + lanes[2*k+1];
        end else if (m_mode == 2'b11) begin
            red[0] = total_sum;
        end else begin
            for (int i = 0; i < NL; i++) red[i] = lanes[i];
        end
        for (int i = 0; i < NL; i++) m_acc[i] = lane_update(m_acc[i] + red[i]);
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (byp || last) begin
            e = '0;
            for (int i = 0; i < NL; i++) e[CW + i*AW +: AW] = AW'(m_acc[i]);
            e[CW-1:0] = CW'(m_cnt);
            exp_q.push_back(e);
            model_clear();
        end else begin
            m_open = 1'b1;
        end
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic send_beat(input logic [1:0] m, input logic [NL*IW-1:0] d,
                             input logic last);
        int  waits = 0;
        bit  done  = 0;
        mode     = m;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!done) begin
            #2;
            if (in_ready) begin
                model_beat(m, d, last);
                done = 1;
            end
            @(negedge clk);
            if (!done) begin
                waits++;
                if (waits > 100) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waits);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 2;
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        rdy_mode = 0;
    endtask

    // Reset is asserted between edges so its effect is checked before any
    // clock edge could hide a missing asynchronous clear.
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_count", out_count, 0);
        check("rst_in_ready",  in_ready,  1);
        exp_q.delete();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       out_ready = 1'b0;
                2:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            check("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
            if (exp_q.size() != 0) begin
                check("out_valid", out_valid, 1);
                check("out_data",  out_data,  exp_q[0][EW-1:CW]);
                check("out_count", out_count, exp_q[0][CW-1:0]);
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                check("out_valid_idle", out_valid, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        mode     = 2'b00;
        model_clear();
        #3;
        check("init_out_valid", out_valid, 0);
        check("init_out_data",  out_data,  0);
        check("init_out_count", out_count, 0);
        check("init_in_ready",  in_ready,  1);
        @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);

        // Bypass single beat; in_last ignored.
        send_beat(2'b00, pack4(1, 2, 3, 4), 1'b0);
        idle(2);

        // Full reduce over three beats -> 30, count 3.
        send_beat(2'b11, pack4(1, 2, 3, 4), 1'b0);
        send_beat(2'b11, pack4(1, 2, 3, 4), 1'b0);
        send_beat(2'b11, pack4(1, 2, 3, 4), 1'b1);
        idle(1);

        // Pairwise, cancelling beats -> all zero, count 2.
        send_beat(2'b01, pack4(1, 2, 3, 4), 1'b0);
        send_beat(2'b01, pack4(-1, -2, -3, -4), 1'b1);

        // Reserved code behaves as bypass, including extreme lane values.
        send_beat(2'b10, pack4(-5, 7, -32768, 32767), 1'b0);

        // Mode changes after the first beat are ignored.
        send_beat(2'b01, pack4(10, 20, 30, 40), 1'b0);
        send_beat(2'b11, pack4(1, 1, 1, 1), 1'b0);
        send_beat(2'b00, pack4(2, 2, 2, 2), 1'b1);
        drain();

        // Backpressure: result held for 5 cycles, then replaced by a closing
        // beat accepted in the same edge the old result is consumed.
        rdy_mode = 1;
        send_beat(2'b11, pack4(7, 8, 9, 10), 1'b1);
        idle(5);
        rdy_mode = 2;
        send_beat(2'b00, pack4(-1, 100, -200, 300), 1'b1);
        drain();

        // Large full-mode group crossing 2^19-1 (wraps, or clamps with sat).
        repeat (5) send_beat(2'b11, pack4(32767, 32767, 32767, 32767), 1'b0);
        send_beat(2'b11, pack4(32767, 32767, 32767, 32767), 1'b1);
        // Beat counter saturates at 255.
        repeat (259) send_beat(2'b11, pack4(1, 0, 0, 0), 1'b0);
        send_beat(2'b11, pack4(1, 0, 0, 0), 1'b1);
        drain();

        // Reset mid-group discards the partial sum.
        send_beat(2'b11, pack4(1, 2, 3, 4), 1'b0);
        send_beat(2'b11, pack4(1, 2, 3, 4), 1'b0);
        idle(1);
        do_reset();
        send_beat(2'b11, pack4(5, 0, 0, 0), 1'b1);
        drain();

        // Reset with a result pending clears out_valid immediately.
        rdy_mode = 1;
        send_beat(2'b00, pack4(9, 9, 9, 9), 1'b0);
        idle(1);
        do_reset();
        rdy_mode = 0;

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_beat(2'($urandom_range(0, 3)),
                      {$urandom(), $urandom()},
                      ($urandom_range(0, 3) == 0));
        end
        send_beat(2'b01, pack4(3, 3, 3, 3), 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
